gate_unit_arbiter: RTL

//  Shares one registered mux-based logic-gate unit (a, b, 2-bit sel -> y) among NREQ requesters.

---
 rtl/gate_unit_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/gate_unit_arbiter.sv
// Round-robin arbiter sharing one registered bitwise gate unit (AND/OR/XOR/NAND)
// among NREQ valid/ready requesters, with a single-entry result register.
module gate_unit_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 8,
  parameter int unsigned IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*2-1:0] req_sel,
  output logic [NREQ-1:0]   req_ready,
  output logic              resp_valid,
  output logic [W-1:0]      resp_data,
  output logic [IDW-1:0]    resp_id,
  input  logic              resp_ready,
  output logic [15:0]       busy_cnt
);

  localparam int unsigned SELW = 2;
  localparam int unsigned CNTW = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   rr_ptr_nxt_c;
  logic             slot_free_c;
  logic             found_c;
  logic             grant_c;
  logic [IDW-1:0]   winner_c;
  logic [IDW-1:0]   cand_c;
  logic [W-1:0]     win_a_c;
  logic [W-1:0]     win_b_c;
  logic [SELW-1:0]  win_sel_c;
  logic [W-1:0]     result_c;

  function automatic logic [W-1:0] gate_op(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic [SELW-1:0] sel);
    logic [W-1:0] r;
    case (sel)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = a ^ b;
      default: r = ~(a & b);
    endcase
    return r;
  endfunction

  assign resp_valid  = (state == FULL);
  assign slot_free_c = ~resp_valid | resp_ready;

  // Search starting at rr_ptr and wrapping; first valid requester wins.
  always_comb begin
    found_c  = 1'b0;
    winner_c = '0;
    cand_c   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand_c = IDW'((32'(rr_ptr) + k) % NREQ);
      if (!found_c && req_valid[cand_c]) begin
        found_c  = 1'b1;
        winner_c = cand_c;
      end
    end
  end

  // Grant is suppressed while reset is asserted so no handshake completes.
  assign grant_c   = found_c & slot_free_c & rst_n;
  assign req_ready = grant_c ? (NREQ'(1) << winner_c) : '0;

  assign win_a_c   = req_a[32'(winner_c)*W +: W];
  assign win_b_c   = req_b[32'(winner_c)*W +: W];
  assign win_sel_c = req_sel[32'(winner_c)*SELW +: SELW];
  assign result_c  = gate_op(win_a_c, win_b_c, win_sel_c);

  assign rr_ptr_nxt_c = (winner_c == IDW'(NREQ - 1)) ? '0 : winner_c + IDW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: begin
        if (grant_c) state_nxt = FULL;
      end
      FULL: begin
        if (grant_c)         state_nxt = FULL;
        else if (resp_ready) state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Result register, pointer and op counter update only on an accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_data <= '0;
      resp_id   <= '0;
      rr_ptr    <= '0;
      busy_cnt  <= '0;
    end else if (grant_c) begin
      resp_data <= result_c;
      resp_id   <= winner_c;
      rr_ptr    <= rr_ptr_nxt_c;
      busy_cnt  <= busy_cnt + CNTW'(1);
    end
  end

endmodule
